rv_ifu: RTL and testbench

Instruction fetch unit producing the IF→ID message consumed by the decode stage. It holds the PC and issues single-outstanding fetches on a req/gnt/rvalid instruction-memory port. Each returned instruction is packed as {pc, inst} and presented to decode with a valid/ready handshake. It accepts PC redirects from the branch/jump path and squashes any stale fetch.

---
 rtl/rv_ifu.sv | 117 +++++++++++
 tb/tb_rv_ifu.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_ifu.sv
`default_nettype none
// ==== rv_ifu : single-outstanding instruction fetch unit producing the IF->ID message ====
// ==== rev 1.0                                                                        ====
module rv_ifu #(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int          IF_ID_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_en,
  output logic                   imem_req,
  output logic [WIDTH-1:0]       imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [WIDTH-1:0]       imem_rdata,
  input  logic                   redirect_valid,
  input  logic [WIDTH-1:0]       redirect_pc,
  output logic                   if_id_valid,
  input  logic                   if_id_ready,
  output logic [IF_ID_WIDTH-1:0] IF_ID_message,
  output logic [31:0]            fetch_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]             r_state;
  logic [WIDTH-1:0]       r_pc;
  logic                   r_kill;
  logic [IF_ID_WIDTH-1:0] r_msg;
  logic [31:0]            r_count;

  logic [WIDTH-1:0]       w_redirect_pc;
  logic [1:0]             w_resume;

  assign w_redirect_pc = redirect_pc & ~(WIDTH'(3));
  assign w_resume      = fetch_en ? S_REQ : S_IDLE;

  assign imem_req      = (r_state == S_REQ);
  assign imem_addr     = r_pc;
  assign if_id_valid   = (r_state == S_HOLD);
  assign IF_ID_message = r_msg;
  assign fetch_count   = r_count;

  // Redirect outranks every other event; a granted or outstanding fetch is marked stale via r_kill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC[WIDTH-1:0];
      r_kill  <= 1'b0;
      r_msg   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect_valid) begin
            r_pc <= w_redirect_pc;
          end else if (fetch_en) begin
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (redirect_valid) begin
            r_pc <= w_redirect_pc;
            if (imem_gnt) begin
              r_state <= S_WAIT;
              r_kill  <= 1'b1;
            end
          end else if (imem_gnt) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            r_pc <= w_redirect_pc;
            if (imem_rvalid) begin
              r_kill  <= 1'b0;
              r_state <= w_resume;
            end else begin
              r_kill <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (r_kill) begin
              r_kill  <= 1'b0;
              r_state <= w_resume;
            end else begin
              r_msg   <= {r_pc, imem_rdata};
              r_pc    <= r_pc + WIDTH'(4);
              r_state <= S_HOLD;
            end
          end
        end
        default: begin
          if (redirect_valid) begin
            r_pc    <= w_redirect_pc;
            r_state <= w_resume;
          end else if (if_id_ready) begin
            r_state <= w_resume;
          end
        end
      endcase
    end
  end

  // A handshake coinciding with a redirect in HOLD still counts as delivered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 32'd0;
    end else if ((r_state == S_HOLD) && if_id_ready) begin
      r_count <= r_count + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv_ifu.sv
`default_nettype none
// ==== tb_rv_ifu : scoreboard bench for rv_ifu ====
// ==== rev 1.0                                 ====
module tb_rv_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_id_valid;
  logic [63:0] IF_ID_message;
  logic [31:0] fetch_count;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] sb_q[$];
  logic [63:0] mon_exp;

  rv_ifu #(
    .WIDTH       (32),
    .RESET_PC    (32'h8000_0000),
    .IF_ID_WIDTH (64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_ready    (if_id_ready),
    .IF_ID_message  (IF_ID_message),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Every delivered message must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && if_id_valid && if_id_ready) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: delivered %h, required no delivery", IF_ID_message);
      end else begin
        mon_exp = sb_q.pop_front();
        if (IF_ID_message !== mon_exp) begin
          n_err++;
          $display("FAIL sb_msg: got %h, required %h", IF_ID_message, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_en = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; if_id_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b, required 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h8000_0000) begin n_err++; $display("FAIL rst_addr: got %h, required 80000000", imem_addr); end
    n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, required 0", if_id_valid); end
    n_cmp++; if (IF_ID_message !== 64'd0) begin n_err++; $display("FAIL rst_msg: got %h, required 0", IF_ID_message); end
    n_cmp++; if (fetch_count !== 32'd0) begin n_err++; $display("FAIL rst_count: got %0d, required 0", fetch_count); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    fetch_en = 1'b1; if_id_ready = 1'b1;
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0000) begin
      n_err++; $display("FAIL basic_req: got req=%b addr=%h, required req=1 addr=80000000", imem_req, imem_addr); end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0010_0513;
    sb_q.push_back({32'h8000_0000, 32'h0010_0513});
    tick();
    imem_rvalid = 1'b0;
    n_cmp++; if (if_id_valid !== 1'b1 || IF_ID_message !== {32'h8000_0000, 32'h0010_0513}) begin
      n_err++; $display("FAIL basic_msg: got valid=%b msg=%h, required valid=1 msg=8000000000100513", if_id_valid, IF_ID_message); end
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0004 || fetch_count !== 32'd1) begin
      n_err++; $display("FAIL basic_next: got req=%b addr=%h cnt=%0d, required req=1 addr=80000004 cnt=1", imem_req, imem_addr, fetch_count); end
  endtask

  task automatic test_backpressure();
    if_id_ready = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0020_0593;
    sb_q.push_back({32'h8000_0004, 32'h0020_0593});
    tick();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (if_id_valid !== 1'b1 || IF_ID_message !== {32'h8000_0004, 32'h0020_0593} || imem_req !== 1'b0 || fetch_count !== 32'd1) begin
        n_err++; $display("FAIL bp_hold[%0d]: got valid=%b msg=%h req=%b cnt=%0d, required valid=1 msg=8000000400200593 req=0 cnt=1",
                          i, if_id_valid, IF_ID_message, imem_req, fetch_count); end
      tick();
    end
    if_id_ready = 1'b1;
    tick();
    n_cmp++; if (fetch_count !== 32'd2 || imem_req !== 1'b1 || imem_addr !== 32'h8000_0008) begin
      n_err++; $display("FAIL bp_release: got cnt=%0d req=%b addr=%h, required cnt=2 req=1 addr=80000008", fetch_count, imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    n_cmp++; if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8000_0100) begin
      n_err++; $display("FAIL rdw_squash: got valid=%b req=%b addr=%h, required valid=0 req=1 addr=80000100", if_id_valid, imem_req, imem_addr); end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0030_0613;
    sb_q.push_back({32'h8000_0100, 32'h0030_0613});
    tick();
    imem_rvalid = 1'b0;
    n_cmp++; if (if_id_valid !== 1'b1 || IF_ID_message[63:32] !== 32'h8000_0100) begin
      n_err++; $display("FAIL rdw_pc: got valid=%b pc=%h, required valid=1 pc=80000100", if_id_valid, IF_ID_message[63:32]); end
    tick();
  endtask

  task automatic test_redirect_gnt();
    imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0203;
    tick();
    imem_gnt = 1'b0; redirect_valid = 1'b0;
    n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h8000_0200) begin
      n_err++; $display("FAIL rdg_wait: got req=%b addr=%h, required req=0 addr=80000200", imem_req, imem_addr); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_F00D;
    tick();
    imem_rvalid = 1'b0;
    n_cmp++; if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8000_0200) begin
      n_err++; $display("FAIL rdg_squash: got valid=%b req=%b addr=%h, required valid=0 req=1 addr=80000200", if_id_valid, imem_req, imem_addr); end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0040_0693;
    sb_q.push_back({32'h8000_0200, 32'h0040_0693});
    tick();
    imem_rvalid = 1'b0;
    tick();
    n_cmp++; if (fetch_count !== 32'd4 || imem_addr !== 32'h8000_0204) begin
      n_err++; $display("FAIL rdg_count: got cnt=%0d addr=%h, required cnt=4 addr=80000204", fetch_count, imem_addr); end
  endtask

  task automatic test_redirect_hold();
    if_id_ready = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0713;
    tick();
    imem_rvalid = 1'b0;
    n_cmp++; if (if_id_valid !== 1'b1) begin n_err++; $display("FAIL rdh_hold: got valid=%b, required 1", if_id_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
    tick();
    redirect_valid = 1'b0; if_id_ready = 1'b1;
    n_cmp++; if (if_id_valid !== 1'b0 || fetch_count !== 32'd4 || imem_req !== 1'b1 || imem_addr !== 32'h8000_0300) begin
      n_err++; $display("FAIL rdh_drop: got valid=%b cnt=%0d req=%b addr=%h, required valid=0 cnt=4 req=1 addr=80000300",
                        if_id_valid, fetch_count, imem_req, imem_addr); end
  endtask

  task automatic test_gnt_delay();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) imem_gnt = 1'b1;
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0300) begin
        n_err++; $display("FAIL gd_stable[%0d]: got req=%b addr=%h, required req=1 addr=80000300", i, imem_req, imem_addr); end
      tick();
    end
    imem_gnt = 1'b0; fetch_en = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0060_0793;
    sb_q.push_back({32'h8000_0300, 32'h0060_0793});
    tick();
    imem_rvalid = 1'b0;
    n_cmp++; if (if_id_valid !== 1'b1) begin n_err++; $display("FAIL gd_valid: got %b, required 1", if_id_valid); end
    tick();
    tick();
    n_cmp++; if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || fetch_count !== 32'd5) begin
      n_err++; $display("FAIL gd_idle: got req=%b valid=%b cnt=%0d, required req=0 valid=0 cnt=5", imem_req, if_id_valid, fetch_count); end
  endtask

  task automatic test_async_reset();
    fetch_en = 1'b1;
    tick();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h8000_0000 || if_id_valid !== 1'b0 || IF_ID_message !== 64'd0 || fetch_count !== 32'd0) begin
      n_err++; $display("FAIL ar_outputs: got req=%b addr=%h valid=%b msg=%h cnt=%0d, required req=0 addr=80000000 valid=0 msg=0 cnt=0",
                        imem_req, imem_addr, if_id_valid, IF_ID_message, fetch_count); end
    tick();
    rst = 1'b0; fetch_en = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_BABE;
    tick();
    imem_rvalid = 1'b0;
    tick();
    n_cmp++; if (if_id_valid !== 1'b0 || imem_req !== 1'b0 || IF_ID_message !== 64'd0) begin
      n_err++; $display("FAIL ar_late_rvalid: got valid=%b req=%b msg=%h, required valid=0 req=0 msg=0", if_id_valid, imem_req, IF_ID_message); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_redirect_gnt();
    test_redirect_hold();
    test_gnt_delay();
    test_async_reset();
    n_cmp++; if (sb_q.size() != 0) begin
      n_err++; $display("FAIL sb_leftover: got %0d undelivered, required 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
